// File: rtl/coproc_bridge_pkg.sv
// Shared types and constants for the coprocessor bridge: FSM encoding,
// request-kind codes and the data word returned on a timeout.
package coproc_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK,
      ST_DONE
   } state_t;

   localparam logic        KIND_LOGIC   = 1'b0;
   localparam logic        KIND_PY      = 1'b1;
   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

   function automatic int unsigned timer_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/coproc_bridge_if.sv
// Host-side request/response channel of the coprocessor bridge.
// The master modport is the bridge; the slave modport is the host.
interface coproc_bridge_if #(
   parameter int TAG_W = 4
) ();

   logic             host_req_valid;
   logic             host_req_ready;
   logic             host_req_kind;
   logic [31:0]      host_req_addr;
   logic [TAG_W-1:0] host_req_tag;

   logic             host_rsp_valid;
   logic [TAG_W-1:0] host_rsp_tag;
   logic [31:0]      host_rsp_data;
   logic             host_rsp_ready;

   modport master (
      output host_req_valid, host_req_kind, host_req_addr, host_req_tag, host_rsp_ready,
      input  host_req_ready, host_rsp_valid, host_rsp_tag, host_rsp_data
   );

   modport slave (
      input  host_req_valid, host_req_kind, host_req_addr, host_req_tag, host_rsp_ready,
      output host_req_ready, host_rsp_valid, host_rsp_tag, host_rsp_data
   );

endinterface

// File: rtl/coproc_bridge_timeout_timer.sv
// Transaction timeout counter: cleared while idle, counts while enabled and
// parks on the last value, flagging expiry there.
module coproc_timeout_timer
   import coproc_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned    CW   = timer_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/coproc_bridge.sv
// Bridges two CPU request channels (logic, python) onto a single tagged host
// request/response port, one outstanding transaction at a time, with timeout.
module coproc_bridge
   import coproc_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TAG_W          = 4
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                logic_req,
   input  logic [31:0]         logic_addr,
   output logic                logic_ack,
   output logic [31:0]         logic_data,

   input  logic                py_req,
   input  logic [31:0]         py_code_addr,
   output logic                py_ack,
   output logic [31:0]         py_result,

   coproc_bridge_if.master     host,

   output logic                busy,
   output logic                timeout_err,
   output logic [31:0]         txn_count,
   output logic [15:0]         drop_count
);

   state_t           state_q, state_d;
   logic             kind_q;
   logic [31:0]      addr_q;
   logic [TAG_W-1:0] tag_q;

   logic timing, expired;
   logic rsp_fire, rsp_hit, timeout_fire, complete;
   logic req_valid_c, rsp_ready_c;

   coproc_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!timing),
      .enable  (timing),
      .expired (expired)
   );

   assign timing       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign rsp_fire     = host.host_rsp_valid && rsp_ready_c;
   assign rsp_hit      = (state_q == ST_WAIT) && rsp_fire && (host.host_rsp_tag == tag_q);
   // a matching response on the expiry cycle wins over the timeout
   assign timeout_fire = timing && expired && !rsp_hit;
   assign complete     = rsp_hit || timeout_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (logic_req || py_req) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (expired)                                  state_d = ST_ACK;
            else if (req_valid_c && host.host_req_ready)  state_d = ST_WAIT;
         end
         ST_WAIT:  if (complete) state_d = ST_ACK;
         ST_ACK:   state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_valid_c = (state_q == ST_ISSUE);
      rsp_ready_c = rst_n && (state_q != ST_ISSUE);
      busy        = (state_q != ST_IDLE);
      logic_ack   = (state_q == ST_ACK) && (kind_q == KIND_LOGIC);
      py_ack      = (state_q == ST_ACK) && (kind_q == KIND_PY);
   end

   assign host.host_req_valid = req_valid_c;
   assign host.host_rsp_ready = rsp_ready_c;
   assign host.host_req_kind  = kind_q;
   assign host.host_req_addr  = addr_q;
   assign host.host_req_tag   = tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_q      <= KIND_LOGIC;
         addr_q      <= '0;
         tag_q       <= '0;
         logic_data  <= '0;
         py_result   <= '0;
         timeout_err <= 1'b0;
         txn_count   <= '0;
         drop_count  <= '0;
      end else begin
         if (state_q == ST_IDLE && (logic_req || py_req)) begin
            kind_q <= logic_req ? KIND_LOGIC : KIND_PY;
            addr_q <= logic_req ? logic_addr : py_code_addr;
         end
         if (complete) begin
            if (kind_q == KIND_LOGIC) logic_data <= rsp_hit ? host.host_rsp_data : TIMEOUT_DATA;
            else                      py_result  <= rsp_hit ? host.host_rsp_data : TIMEOUT_DATA;
            tag_q     <= tag_q + TAG_W'(1);
            txn_count <= txn_count + 32'd1;
            if (!rsp_hit) timeout_err <= 1'b1;
         end
         if (rsp_fire && !rsp_hit && drop_count != '1) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/coproc_bridge.md
COPROC_BRIDGE -- requirements
Module: coproc_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles from request issue to matching response.
REQ-002 SHALL have parameter TAG_W, default 4, meaning transaction tag width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have CPU logic channel: logic_req in 1, logic_addr in 32, logic_ack out 1, logic_data out 32.
REQ-006 SHALL have CPU python channel: py_req in 1, py_code_addr in 32, py_ack out 1, py_result out 32.
REQ-007 SHALL have host request port: host_req_valid out 1, host_req_ready in 1, host_req_kind out 1 (0=logic, 1=python), host_req_addr out 32, host_req_tag out TAG_W.
REQ-008 SHALL have host response port: host_rsp_valid in 1, host_rsp_tag in TAG_W, host_rsp_data in 32, host_rsp_ready out 1.
REQ-009 SHALL have status outputs: busy out 1, timeout_err out 1 (sticky), txn_count out 32, drop_count out 16.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE: on logic_req=1 capture kind=0, addr=logic_addr; else on py_req=1 capture kind=1, addr=py_code_addr; go ISSUE next cycle; logic has fixed priority when both asserted.
REQ-012 ISSUE: host_req_valid=1 with kind/addr/tag stable until the cycle host_req_valid&&host_req_ready, then go WAIT.
REQ-013 WAIT: host_rsp_ready=1; a response with host_rsp_tag equal to current tag completes the transaction; mismatched tag is discarded and drop_count increments (saturating at 16'hFFFF).
REQ-014 host_rsp_ready SHALL also be 1 in IDLE and DONE; any response there is discarded and counted as dropped.
REQ-015 On completion, the matching ack (logic_ack or py_ack per kind) SHALL pulse for exactly one cycle with logic_data/py_result = host_rsp_data registered, i.e. ack one cycle after the accepted response.
REQ-016 logic_data and py_result SHALL hold their last value until overwritten by the next completion of their own channel.
REQ-017 Timeout counter SHALL start at 0 on entering ISSUE and increment each cycle in ISSUE and WAIT; on reaching TIMEOUT_CYCLES-1 without completion, ack SHALL pulse with data 32'hFFFF_FFFF and timeout_err SHALL set.
REQ-018 A timeout in ISSUE SHALL deassert host_req_valid the following cycle (request withdrawn).
REQ-019 Response accepted on the same cycle the timeout fires SHALL win (normal completion, no error).
REQ-020 After each completion or timeout the tag SHALL increment modulo 2^TAG_W and txn_count SHALL increment (wraps at 2^32).
REQ-021 DONE: lasts exactly one cycle after the ack pulse; request inputs are ignored there so a req still high from the acked cycle is not re-issued; then IDLE.
REQ-022 busy SHALL be 1 in ISSUE, WAIT, DONE and 0 in IDLE.
REQ-023 Requests arriving while busy SHALL NOT be captured; the CPU holds req until its ack.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, tag=0, counters=0, timeout_err=0, all acks/valids=0, logic_data=py_result=host_req_addr=0, host_req_kind=0, host_rsp_ready=0 while in reset.
REQ-025 Reset mid-transaction SHALL abandon it with no ack; a later response with the old tag is dropped after reset as any stray response.

Structure
REQ-026 SHALL place state encoding, KIND_LOGIC/KIND_PY constants and TIMEOUT_DATA=32'hFFFF_FFFF in shared package coproc_bridge_pkg.
REQ-027 SHALL factor the timeout counter into sub-module coproc_timeout_timer (clear, enable, expired).

Verification
REQ-028 logic_req addr 0x40, host ready immediately, response tag 0 data 0xABCD1234 two cycles later -> one-cycle logic_ack, logic_data=0xABCD1234, txn_count=1, tag now 1.
REQ-029 logic_req and py_req same cycle -> logic served first (kind 0), then py (kind 1, tag 1) after DONE; py_result=host data, both acks single pulses.
REQ-030 TIMEOUT_CYCLES=8, no response -> ack at 8 cycles after ISSUE entry with data 0xFFFFFFFF, timeout_err=1; late response tag 0 then dropped, drop_count=1.
REQ-031 Response with wrong tag during WAIT -> no ack, drop_count+1; correct tag next -> normal ack.
REQ-032 rst_n asserted in WAIT -> immediate IDLE, no ack, all outputs at reset values; next request uses tag 0.
REQ-033 Sixteen transactions with TAG_W=4 -> tag wraps 15 to 0, all complete without drops.
